param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_ram.sv | 30 +++
 rtl/param_sync_fifo.sv | 142 ++++++++++++++
 tb/tb_param_sync_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and read-mode encoding for the synchronous FIFO.
// Latency: none, constants and types only.
// Backpressure: not applicable.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  // Read-port behaviour: registered read data or first-word-fall-through.
  typedef enum logic {
    REGISTERED = 1'b0,
    FWFT       = 1'b1
  } fifo_mode_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: one write port, one read port.
// Latency: write lands at the clock edge, read data is combinational from raddr_i.
// Backpressure: none; the caller decides when a write is legal.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  // Storage is deliberately left unreset so it can map onto RAM macros.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO with occupancy flags and sticky error flags.
// Latency: registered mode returns data one cycle after an accepted read; FWFT shows the head word the cycle after it is written.
// Backpressure: writes are dropped while full and reads while empty; each drop raises a sticky flag.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam fifo_mode_t MODE = (FWFT != 0) ? fifo_pkg::FWFT : REGISTERED;

  // Reject unusable parameter sets at elaboration.
  if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two in 2..1024");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_width
    $error("param_sync_fifo: DATA_WIDTH must be in 1..64");
  end
  if (AF_LEVEL > DEPTH || AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("param_sync_fifo: need AF_LEVEL <= DEPTH and AE_LEVEL < AF_LEVEL");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign almost_full  = (count_q >= PW'(AF_LEVEL));
  assign almost_empty = (count_q <= PW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A full FIFO still accepts a read, an empty one still accepts a write.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Next-state for pointers, occupancy and the sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Clear first so a same-cycle error event takes priority.
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en && full)  ovf_d = 1'b1;
    if (rd_en && empty) unf_d = 1'b1;
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  if (MODE == REGISTERED) begin : g_reg_read
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Capture the head word on an accepted read; hold it otherwise.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= ram_rdata;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_fwft_read
    // Gate on empty so reset and an empty FIFO never expose stale RAM contents.
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : ram_rdata;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
`timescale 1ns/1ps
module tb_param_sync_fifo;

  localparam int DEPTH = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;

  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
  logic [7:0] f_wr_data = 8'h00;
  logic [7:0] f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_count;

  param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .FWFT(0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .FWFT(1)) dut_f (
    .clk(clk), .reset(reset), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs always change 2ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: a queue of words plus the sticky flags and the read register.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0, m_unf = 1'b0, m_vld = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_was_full, m_was_empty;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_vld  = 1'b0;
      m_data = 8'h00;
    end else begin
      m_was_full  = (mq.size() == DEPTH);
      m_was_empty = (mq.size() == 0);
      m_vld = rd_en && !m_was_empty;
      if (m_vld) m_data = mq.pop_front();
      if (wr_en && !m_was_full) mq.push_back(wr_data);
      if (wr_en && m_was_full) m_ovf = 1'b1;
      else if (clr_err) m_ovf = 1'b0;
      if (rd_en && m_was_empty) m_unf = 1'b1;
      else if (clr_err) m_unf = 1'b0;
    end
  end

  // Every falling edge the registered-mode DUT must agree with the model.
  always @(negedge clk) begin
    chk("m_count",        count,        mq.size());
    chk("m_full",         full,         mq.size() == DEPTH);
    chk("m_empty",        empty,        mq.size() == 0);
    chk("m_almost_full",  almost_full,  mq.size() >= DEPTH - 2);
    chk("m_almost_empty", almost_empty, mq.size() <= 2);
    chk("m_rd_valid",     rd_valid,     m_vld);
    chk("m_rd_data",      rd_data,      m_data);
    chk("m_overflow",     overflow,     m_ovf);
    chk("m_underflow",    underflow,    m_unf);
  end

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({name, "_vld"}, rd_valid, 1);
    chk({name, "_dat"}, rd_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_af;
    repeat (2) tick();
    reset = 1'b1;

    // Reset state after release.
    chk("rst_empty",    empty,        1);
    chk("rst_aempty",   almost_empty, 1);
    chk("rst_count",    count,        0);
    chk("rst_rd_data",  rd_data,      0);
    chk("rst_full",     full,         0);
    chk("rst_afull",    almost_full,  0);
    chk("rst_rd_valid", rd_valid,     0);

    // Fill 0x00..0x0F and note where almost_full first rises.
    first_af = -1;
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      if (almost_full && first_af < 0) first_af = int'(count);
    end
    chk("fill_af_first", first_af, 14);
    chk("fill_full",     full,     1);
    chk("fill_count",    count,    16);
    push(8'hEE);
    chk("ovf_set",   overflow, 1);
    chk("ovf_count", count,    16);

    // Drain with gaps so each rd_valid is an isolated one-cycle pulse.
    for (int i = 0; i < 16; i++) begin
      chk("drain_vld_pre", rd_valid, 0);
      pop_chk("drain", 8'(i));
      tick();
      chk("drain_vld_drop", rd_valid, 0);
    end
    chk("drain_empty", empty, 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("unf_set",   underflow, 1);
    chk("unf_vld",   rd_valid,  0);
    chk("unf_hold",  rd_data,   8'h0F);

    // Error clear collides with a fresh underflow: the set wins.
    clr_err = 1'b1; rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("clr_ovf",       overflow,  0);
    chk("clr_unf_wins",  underflow, 1);
    tick(); clr_err = 1'b0;
    chk("clr_unf", underflow, 0);

    // Concurrent read and write at count 5.
    for (int i = 0; i < 5; i++) push(8'(32'h10 + i));
    chk("rw_start_count", count, 5);
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1; wr_data = 8'(32'h15 + k); rd_en = 1'b1;
      tick();
      chk("rw_count", count, 5);
      chk("rw_vld",   rd_valid, 1);
      chk("rw_dat",   rd_data, 8'(32'h10 + k));
    end
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 5; i++) pop_chk("rw_tail", 8'(32'h1A + i));

    // Concurrent read and write while full: only the read goes through.
    for (int i = 0; i < 16; i++) push(8'(32'h30 + i));
    wr_en = 1'b1; wr_data = 8'hFF; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("fullrw_count", count,    15);
    chk("fullrw_dat",   rd_data,  8'h30);
    chk("fullrw_ovf",   overflow, 1);
    for (int i = 0; i < 15; i++) pop_chk("fullrw_tail", 8'(32'h31 + i));
    clr_err = 1'b1; tick(); clr_err = 1'b0;

    // 40 push/pop pairs carry both pointers through their wrap.
    for (int i = 0; i < 40; i++) begin
      push(8'(32'h40 + i));
      pop_chk("wrap", 8'(32'h40 + i));
    end
    chk("wrap_ovf",   overflow,  0);
    chk("wrap_unf",   underflow, 0);
    chk("wrap_empty", empty,     1);

    // Reset mid-operation takes effect without a clock edge.
    for (int i = 0; i < 7; i++) push(8'(32'h60 + i));
    chk("pre_rst_count", count, 7);
    reset = 1'b0;
    #1;
    chk("async_rst_count", count,   0);
    chk("async_rst_empty", empty,   1);
    chk("async_rst_rdat",  rd_data, 0);
    tick(); tick();
    reset = 1'b1;
    push(8'h77);
    chk("post_rst_first_wr", count, 1);
    pop_chk("post_rst_rd", 8'h77);
    chk("post_rst_empty", empty, 1);

    // First-word-fall-through instance.
    chk("fwft_idle_vld", f_rd_valid, 0);
    chk("fwft_idle_dat", f_rd_data,  0);
    f_wr_en = 1'b1; f_wr_data = 8'hA5;
    tick();
    f_wr_en = 1'b0;
    chk("fwft_vld",   f_rd_valid, 1);
    chk("fwft_dat",   f_rd_data,  8'hA5);
    chk("fwft_count", f_count,    1);
    tick();
    chk("fwft_hold", f_rd_data, 8'hA5);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    chk("fwft_pop_vld",   f_rd_valid, 0);
    chk("fwft_pop_empty", f_empty,    1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
